// File: rtl/cpu_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_loader_pkg
// Description : Shared types, constants and header decode for the CPU
//               program loader.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_loader_pkg;

    // Section identifiers carried in the top two bits of a header word
    typedef enum logic [1:0] {
        SEC_ROM   = 2'd0,
        SEC_INSTR = 2'd1,
        SEC_INPUT = 2'd2,
        SEC_END   = 2'd3
    } sec_id_e;

    // Loader states
    typedef enum logic [1:0] {
        HDR  = 2'd0,
        DATA = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } loader_state_e;

    // Region layout
    localparam int C_REGION_WORDS = 1024;
    localparam int C_ROM_BASE     = 0;
    localparam int C_INSTR_BASE   = 1024;
    localparam int C_INPUT_BASE   = 2048;

    // Header field positions (id sits at the MSBs of the word)
    localparam int C_ID_W    = 2;
    localparam int C_COUNT_W = 16;
    localparam int C_COUNT_LSB = 0;

    // Decoded view of a header word
    typedef struct packed {
        sec_id_e                id;
        logic [C_COUNT_W-1:0]   count;
        logic                   is_end;
        logic                   is_empty;
        logic                   is_oversize;
    } hdr_t;

    // Classify a header: END, empty section, or a count too big for a region
    function automatic hdr_t decode_header(
        input logic [C_ID_W-1:0]    id_bits,
        input logic [C_COUNT_W-1:0] count_bits,
        input int unsigned          region_words
    );
        hdr_t h;
        h.id          = sec_id_e'(id_bits);
        h.count       = count_bits;
        h.is_end      = (h.id == SEC_END);
        h.is_empty    = (count_bits == '0);
        h.is_oversize = ({16'd0, count_bits} > region_words);
        return h;
    endfunction

endpackage : cpu_loader_pkg
`default_nettype wire

// File: rtl/cpu_program_loader.sv
`default_nettype none
// ============================================================================
// Module      : cpu_program_loader
// Description : Accepts a sectioned word stream, writes each section into its
//               memory region and keeps the CPU in reset until END arrives.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_program_loader
    import cpu_loader_pkg::*;
#(
    parameter int DATA_W       = 32,   // must be at least 18
    parameter int ADDR_W       = 12,
    parameter int REGION_WORDS = C_REGION_WORDS,
    parameter int ROM_BASE     = C_ROM_BASE,
    parameter int INSTR_BASE   = C_INSTR_BASE,
    parameter int INPUT_BASE   = C_INPUT_BASE
) (
    input  logic              clk,
    input  logic              reset_b,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_reset_b,
    output logic              load_done,
    output logic              load_error
);

    loader_state_e       r_state;
    loader_state_e       w_next_state;
    hdr_t                w_hdr;
    logic                w_s_ready;
    logic                w_xfer;
    logic                w_hdr_xfer;
    logic                w_data_xfer;
    logic                w_open_section;
    logic [ADDR_W-1:0]   w_sel_base;

    logic [ADDR_W-1:0]   r_base;
    logic [ADDR_W-1:0]   r_offset;
    logic [C_COUNT_W-1:0] r_remaining;

    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic                r_cpu_reset_b;
    logic                r_load_done;
    logic                r_load_error;

    assign w_hdr = decode_header(s_data[DATA_W-1 -: C_ID_W],
                                 s_data[C_COUNT_LSB +: C_COUNT_W],
                                 REGION_WORDS);

    // State register
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_state <= HDR;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode from accepted headers and the remaining word count
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            HDR: begin
                if (w_xfer) begin
                    if (w_hdr.is_end) begin
                        w_next_state = DONE;
                    end else if (w_hdr.is_oversize) begin
                        w_next_state = ERR;
                    end else if (!w_hdr.is_empty) begin
                        w_next_state = DATA;
                    end
                end
            end
            DATA: begin
                if (w_xfer && (r_remaining == C_COUNT_W'(1))) begin
                    w_next_state = HDR;
                end
            end
            default: w_next_state = r_state;  // DONE and ERR hold until reset
        endcase
    end

    // Handshake, transfer qualifiers and region base selection
    always_comb begin
        w_s_ready      = reset_b && ((r_state == HDR) || (r_state == DATA));
        w_xfer         = s_valid && w_s_ready;
        w_hdr_xfer     = w_xfer && (r_state == HDR);
        w_data_xfer    = w_xfer && (r_state == DATA);
        w_open_section = w_hdr_xfer && !w_hdr.is_end && !w_hdr.is_empty
                         && !w_hdr.is_oversize;
        case (w_hdr.id)
            SEC_INSTR: w_sel_base = ADDR_W'(INSTR_BASE);
            SEC_INPUT: w_sel_base = ADDR_W'(INPUT_BASE);
            default:   w_sel_base = ADDR_W'(ROM_BASE);
        endcase
    end

    // Section pointer: latch base/count on a header, advance on each data word
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_base      <= '0;
            r_offset    <= '0;
            r_remaining <= '0;
        end else if (w_open_section) begin
            r_base      <= w_sel_base;
            r_offset    <= '0;
            r_remaining <= w_hdr.count;
        end else if (w_data_xfer) begin
            r_offset    <= r_offset + ADDR_W'(1);
            r_remaining <= r_remaining - C_COUNT_W'(1);
        end
    end

    // Registered memory write port; strobe lasts one cycle per data transfer
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_mem_we <= w_data_xfer;
            if (w_data_xfer) begin
                r_mem_addr  <= r_base + r_offset;
                r_mem_wdata <= s_data;
            end
        end
    end

    // Sticky status flags and CPU reset release on END
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_cpu_reset_b <= 1'b0;
            r_load_done   <= 1'b0;
            r_load_error  <= 1'b0;
        end else if (w_hdr_xfer) begin
            if (w_hdr.is_end) begin
                r_cpu_reset_b <= 1'b1;
                r_load_done   <= 1'b1;
            end else if (w_hdr.is_oversize) begin
                r_load_error  <= 1'b1;
            end
        end
    end

    assign s_ready     = w_s_ready;
    assign mem_we      = r_mem_we;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign cpu_reset_b = r_cpu_reset_b;
    assign load_done   = r_load_done;
    assign load_error  = r_load_error;

endmodule : cpu_program_loader
`default_nettype wire

// File: tb/tb_cpu_program_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_program_loader
// Description : Directed self-checking bench for cpu_program_loader.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_program_loader;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 12;

    logic              clk;
    logic              reset_b;
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              cpu_reset_b;
    logic              load_done;
    logic              load_error;

    int checks;
    int errors;

    cpu_program_loader #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk        (clk),
        .reset_b    (reset_b),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_reset_b(cpu_reset_b),
        .load_done  (load_done),
        .load_error (load_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one word, let it be accepted at the next rising edge, sample 1 after
    task automatic xfer(input logic [DATA_W-1:0] w);
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = w;
        check("ready_before_xfer", 64'(s_ready), 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        s_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        s_valid = 1'b0;
        reset_b = 1'b0;
        @(negedge clk);
        reset_b = 1'b1;
    endtask

    task automatic check_write(input string tag, input logic [ADDR_W-1:0] a,
                               input logic [DATA_W-1:0] d);
        check({tag, "_we"},   64'(mem_we),    64'd1);
        check({tag, "_addr"}, 64'(mem_addr),  64'(a));
        check({tag, "_data"}, 64'(mem_wdata), 64'(d));
    endtask

    task automatic check_end_accepted(input string tag);
        check({tag, "_we"},    64'(mem_we),      64'd0);
        check({tag, "_done"},  64'(load_done),   64'd1);
        check({tag, "_cpurb"}, 64'(cpu_reset_b), 64'd1);
        check({tag, "_err"},   64'(load_error),  64'd0);
    endtask

    localparam logic [31:0] END_HDR = 32'hC000_0000;

    initial begin
        checks  = 0;
        errors  = 0;
        s_valid = 1'b0;
        s_data  = '0;
        reset_b = 1'b0;

        // ---------------- reset state ----------------
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 64'(s_ready),     64'd0);
        check("rst_we",    64'(mem_we),      64'd0);
        check("rst_addr",  64'(mem_addr),    64'd0);
        check("rst_wdata", 64'(mem_wdata),   64'd0);
        check("rst_cpurb", 64'(cpu_reset_b), 64'd0);
        check("rst_done",  64'(load_done),   64'd0);
        check("rst_err",   64'(load_error),  64'd0);
        @(negedge clk);
        reset_b = 1'b1;
        #1;
        check("hdr_ready", 64'(s_ready), 64'd1);

        // ---------------- 1: ROM x3 then END ----------------
        xfer(32'h0000_0003);
        check("t1_hdr_we", 64'(mem_we), 64'd0);
        xfer(32'hA);  check_write("t1_w0", 12'd0, 32'hA);
        xfer(32'hB);  check_write("t1_w1", 12'd1, 32'hB);
        xfer(32'hC);  check_write("t1_w2", 12'd2, 32'hC);
        check("t1_cpurb_pre", 64'(cpu_reset_b), 64'd0);
        check("t1_done_pre",  64'(load_done),   64'd0);
        xfer(END_HDR);
        check_end_accepted("t1_end");
        idle_cycle();
        check("t1_ready_done", 64'(s_ready), 64'd0);

        // ---------------- 2: INSTR x2, INPUT x1, END ----------------
        apply_reset();
        xfer(32'h4000_0002);
        xfer(32'd5);  check_write("t2_i0", 12'd1024, 32'd5);
        xfer(32'd6);  check_write("t2_i1", 12'd1025, 32'd6);
        xfer(32'h8000_0001);
        check("t2_hdr_we", 64'(mem_we), 64'd0);
        xfer(32'hFFFF_FFF9); check_write("t2_in0", 12'd2048, 32'hFFFF_FFF9);
        xfer(END_HDR);
        check_end_accepted("t2_end");
        idle_cycle();
        check("t2_ready_done", 64'(s_ready), 64'd0);

        // ---------------- 3: INPUT full region, no stalls ----------------
        apply_reset();
        xfer(32'h8000_0400);
        for (int i = 0; i < 1024; i++) begin
            xfer(32'(i));
            check_write("t3_w", 12'(2048 + i), 32'(i));
        end
        // back in HDR: END is accepted directly
        xfer(END_HDR);
        check_end_accepted("t3_end");
        idle_cycle();

        // ---------------- 4: oversize INSTR header ----------------
        apply_reset();
        xfer(32'h4000_0401);
        check("t4_err",   64'(load_error),  64'd1);
        check("t4_ready", 64'(s_ready),     64'd0);
        check("t4_we",    64'(mem_we),      64'd0);
        check("t4_cpurb", 64'(cpu_reset_b), 64'd0);
        check("t4_done",  64'(load_done),   64'd0);
        @(negedge clk);
        s_data = 32'h1234_5678;    // valid stays high, loader must ignore it
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("t4_we_hold",    64'(mem_we),      64'd0);
            check("t4_cpurb_hold", 64'(cpu_reset_b), 64'd0);
            check("t4_err_hold",   64'(load_error),  64'd1);
        end

        // ---------------- 5: ROM x4 with stalls ----------------
        apply_reset();
        xfer(32'h0000_0004);
        for (int i = 0; i < 4; i++) begin
            xfer(32'h100 + 32'(i));
            check_write("t5_w", 12'(i), 32'h100 + 32'(i));
            idle_cycle();
            check("t5_stall_we", 64'(mem_we), 64'd0);
        end
        xfer(END_HDR);
        check_end_accepted("t5_end");

        // ---------------- 6: reset mid-section ----------------
        apply_reset();
        xfer(32'h0000_0004);
        xfer(32'hD0);  check_write("t6_w0", 12'd0, 32'hD0);
        xfer(32'hD1);  check_write("t6_w1", 12'd1, 32'hD1);
        #2;
        reset_b = 1'b0;
        s_valid = 1'b0;
        #1;
        check("t6_rst_we",    64'(mem_we),      64'd0);
        check("t6_rst_addr",  64'(mem_addr),    64'd0);
        check("t6_rst_wdata", 64'(mem_wdata),   64'd0);
        check("t6_rst_ready", 64'(s_ready),     64'd0);
        check("t6_rst_cpurb", 64'(cpu_reset_b), 64'd0);
        @(negedge clk);
        reset_b = 1'b1;
        xfer(32'h0000_0000);
        check("t6_empty_we", 64'(mem_we), 64'd0);
        xfer(END_HDR);
        check_end_accepted("t6_end");
        idle_cycle();
        check("t6_idle_we", 64'(mem_we), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_cpu_program_loader
`default_nettype wire

// File: doc/cpu_program_loader.md
Name: cpu_program_loader

Overview:
Synthesizable loader that fills CPU memory from a word stream before the CPU is released from reset. It accepts sectioned data over a valid/ready input and writes each section into one of three memory regions: ROM at 0, instructions at 1024, inputs/results at 2048. It sits between an external host link and the memory write port. It holds the CPU in reset until an END section arrives.

Parameters:
DATA_W, 32, memory word and stream width; must be at least 18.
ADDR_W, 12, memory address width.
REGION_WORDS, 1024, maximum words per section.
ROM_BASE, 0, base address of section id 0.
INSTR_BASE, 1024, base address of section id 1.
INPUT_BASE, 2048, base address of section id 2.

Ports:
clk  input  1  system clock
reset_b  input  1  asynchronous active-low reset
s_valid  input  1  stream word valid
s_ready  output  1  loader accepts the word
s_data  input  DATA_W  stream word: a header or a data word
mem_we  output  1  memory write enable, registered
mem_addr  output  ADDR_W  memory write address, registered
mem_wdata  output  DATA_W  memory write data, registered
cpu_reset_b  output  1  active-low reset to the CPU, registered
load_done  output  1  END header accepted (sticky)
load_error  output  1  malformed header seen (sticky)

Behaviour:
- Clock and reset: one clock, clk. reset_b is asynchronous and active-low.
- Reset values: state HDR; s_ready 0 while in reset; mem_we 0; mem_addr 0; mem_wdata 0; cpu_reset_b 0; load_done 0; load_error 0.
- Handshake: a transfer occurs on a rising edge where s_valid && s_ready.
  - s_ready is combinational: 1 in HDR and DATA, 0 in DONE and ERR.
  - The source must hold s_data stable while s_valid=1 and s_ready=0.
- Header format:
  - id = s_data[DATA_W-1:DATA_W-2]: 0 ROM, 1 INSTR, 2 INPUT, 3 END.
  - count = s_data[15:0].
  - All other bits are ignored.
- States and transitions:
  - HDR, header accepted with id 0..2:
    - count 0: stay in HDR with no writes.
    - 1 <= count <= REGION_WORDS: load base, set offset 0, remaining = count, go to DATA.
    - count > REGION_WORDS: go to ERR.
  - HDR, header accepted with id 3: go to DONE; count is ignored.
  - DATA, each accepted word:
    - Registers mem_we=1, mem_addr = base + offset, mem_wdata = s_data.
    - offset increments and remaining decrements.
    - When remaining reaches 0 on a transfer, return to HDR.
  - DONE: terminal until reset. load_done=1 and cpu_reset_b=1 on the edge that accepts END.
  - ERR: terminal until reset. load_error=1 and cpu_reset_b stays 0.
- Write latency: one cycle. A transfer at edge k puts the write on the memory port during cycle k to k+1. mem_we drops after one cycle unless another transfer occurred.
- Back-to-back transfers produce back-to-back writes with no bubble. A stalled source (s_valid=0) produces mem_we=0.
- Ordering: END can only be accepted on an edge after the last data write has been presented. cpu_reset_b therefore never rises while a write is pending.
- Address arithmetic: base + offset computed at ADDR_W bits. offset is at most REGION_WORDS-1, so sections never overlap.
- Repeated sections: allowed; each restarts at offset 0 and later data overwrites earlier data.
- Reset mid-load: everything returns to reset values and cpu_reset_b drops to 0 asynchronously. Memory contents already written are not cleared. The host must restart from a header.

Decomposition:
- Package cpu_loader_pkg holds:
  - Section id enum: SEC_ROM, SEC_INSTR, SEC_INPUT, SEC_END.
  - Loader state enum: HDR, DATA, DONE, ERR.
  - Region base constants and REGION_WORDS.
  - Header field position constants.
- Single module; no sub-module. The header decode is a function in the package.

Test Plan:
1. ROM header count=3, then data 0xA,0xB,0xC, then END -> writes to addresses 0,1,2 with 0xA,0xB,0xC, each one cycle after its transfer; load_done=1 and cpu_reset_b=1 after the END edge.
2. INSTR header count=2 with data 5,6, then INPUT header count=1 with data -7, then END -> writes at 1024=5, 1025=6, 2048=0xFFFFFFF9; s_ready=0 after END.
3. INPUT header count=1024, then 1024 words i=0..1023 with no stalls -> 1024 consecutive mem_we cycles at addresses 2048..3071; return to HDR after the last word.
4. INSTR header count=1025 -> load_error=1, s_ready=0, mem_we never asserts, cpu_reset_b stays 0.
5. ROM header count=4 with s_valid toggled every other cycle -> exactly 4 writes; mem_we=0 in stall cycles; addresses 0..3 in order.
6. Assert reset_b low after the 2nd data word of a count=4 section -> outputs reach reset values immediately; after release, header count=0 followed by END -> load_done=1 with no writes.
